// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_add3_shift.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift {acc,sr} left by one.
module bcd_add3_shift
    import bcd_pkg::*;
#(
    parameter int unsigned N_BITS   = 10,
    parameter int unsigned N_DIGITS = 4
) (
    input  logic [DIGIT_W*N_DIGITS+N_BITS-1:0] din,
    output logic [DIGIT_W*N_DIGITS+N_BITS-1:0] dout
);

    localparam int unsigned ACC_W  = DIGIT_W * N_DIGITS;
    localparam int unsigned WORK_W = ACC_W + N_BITS;

    logic [WORK_W-1:0] adj;

    assign adj[N_BITS-1:0] = din[N_BITS-1:0];

    // Digits are corrected independently; no carry crosses a digit boundary.
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic [DIGIT_W-1:0] d;
        assign d = din[N_BITS + DIGIT_W*i +: DIGIT_W];
        assign adj[N_BITS + DIGIT_W*i +: DIGIT_W] = (d >= ADD3_THRESH) ? d + ADD3_VAL : d;
    end

    assign dout = {adj[WORK_W-2:0], 1'b0};

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD controller: one double-dabble iteration per clock,
// busy/done handshake, digit outputs held until the next result is ready.
module bcd_conv_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned N_BITS   = 10,
    parameter int unsigned N_DIGITS = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic [N_BITS-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [3:0]        BCD0,
    output logic [3:0]        BCD1,
    output logic [3:0]        BCD2,
    output logic [3:0]        BCD3
);

    localparam int unsigned ACC_W  = DIGIT_W * N_DIGITS;
    localparam int unsigned WORK_W = ACC_W + N_BITS;
    localparam int unsigned CNT_W  = $clog2(N_BITS + 1);
    localparam int unsigned OUT_W  = (ACC_W > 16) ? ACC_W : 16;

    state_t            state;
    state_t            state_nxt;
    logic [N_BITS-1:0] sr;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  bcd_q;
    logic [WORK_W-1:0] work_nxt;
    logic              accept;
    logic              last_iter;
    logic [OUT_W-1:0]  bcd_pad;

    bcd_add3_shift #(
        .N_BITS   (N_BITS),
        .N_DIGITS (N_DIGITS)
    ) u_add3_shift (
        .din  ({acc, sr}),
        .dout (work_nxt)
    );

    // Next-state decode; start is honoured only in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(N_BITS - 1)) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            if (accept) begin
                sr  <= bin;
                acc <= '0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                {acc, sr} <= work_nxt;
                cnt       <= cnt + CNT_W'(1);
            end
            // Publish only the finished result so the display never sees partial digits.
            if (last_iter) begin
                bcd_q <= work_nxt[WORK_W-1 -: ACC_W];
            end
        end
    end

    assign bcd_pad = OUT_W'(bcd_q);
    assign BCD0    = bcd_pad[3:0];
    assign BCD1    = bcd_pad[7:4];
    assign BCD2    = bcd_pad[11:8];
    assign BCD3    = bcd_pad[15:12];

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed and swept checks for bcd_conv_ctrl at default parameters.
module tb_bcd_conv_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic [15:0] digits;

    int n_checks = 0;
    int n_errors = 0;

    bcd_conv_ctrl #(.N_BITS(10), .N_DIGITS(4)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .BCD0     (BCD0),
        .BCD1     (BCD1),
        .BCD2     (BCD2),
        .BCD3     (BCD3)
    );

    assign digits = {BCD3, BCD2, BCD1, BCD0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Launch one conversion; optionally re-pulse start with bin=7 on edge k+poke.
    task automatic convert(input logic [9:0] v, input logic [15:0] exp, input int poke);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (cycles + 1 == poke) begin
                bin   = 10'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        chk("latency", 32'(cycles), 32'd10);
        chk("busy_cycles", 32'(busy_cnt), 32'd10);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("digits", 32'(digits), 32'(exp));
        @(posedge clk); #1;
        chk("done_width", 32'(done), 32'd0);
        chk("digits_hold", 32'(digits), 32'(exp));
    endtask

    task automatic sweep_one(input int v);
        int cycles;
        @(negedge clk);
        bin   = 10'(v);
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles != 10) chk("sweep_latency", 32'(cycles), 32'd10);
        chk("sweep", 32'(digits), 32'(ref_bcd(v)));
    endtask

    initial begin
        logic [9:0]  vals [3];
        logic [15:0] expd;
        int          done_seen;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        convert(10'd0,    16'h0000, -1);
        convert(10'd1023, 16'h1023, -1);
        convert(10'd599,  16'h0599, -1);
        convert(10'd999,  16'h0999, -1);

        // Start pulse during SHIFT must be ignored.
        convert(10'd512,  16'h0512, 5);

        for (int v = 0; v < 1024; v++) sweep_one(v);

        // Back-to-back with start held and bin changing every cycle.
        vals[0] = 10'd321;
        vals[1] = 10'd87;
        vals[2] = 10'd1000;
        expd    = ref_bcd(1023);
        for (int t = 0; t < 33; t++) begin
            @(negedge clk);
            start = 1'b1;
            bin   = (t % 11 == 0) ? vals[t / 11] : 10'((t * 37 + 5) % 1024);
            @(posedge clk); #1;
            if (t % 11 == 10) begin
                expd = ref_bcd(int'(vals[t / 11]));
                chk("b2b_done", 32'(done), 32'd1);
                chk("b2b_busy_low", 32'(busy), 32'd0);
                chk("b2b_digits", 32'(digits), 32'(expd));
            end else begin
                if (done !== 1'b0) chk("b2b_no_done", 32'(done), 32'd0);
                if (busy !== 1'b1) chk("b2b_busy", 32'(busy), 32'd1);
                if (digits !== expd) chk("b2b_stable", 32'(digits), 32'(expd));
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_done", 32'(done), 32'd0);

        // Reset in the middle of a conversion clears everything and discards it.
        convert(10'd1023, 16'h1023, -1);
        @(negedge clk);
        bin   = 10'd345;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_digits", 32'(digits), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("no_done_after_rst", 32'(done_seen), 32'd0);
        chk("digits_after_rst", 32'(digits), 32'd0);

        convert(10'd345, 16'h0345, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
